// File: rtl/counting_gen_if.sv
// Host-side bus of the symbol-stream generator: buffer load/clear, playback
// trigger and the emitted 2-bit symbol stream with its status flags.
interface counting_gen_if #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int REP_W = 4
);
   logic             wr_en;
   logic [1:0]       wr_data;
   logic             clr;
   logic             start;
   logic [REP_W-1:0] rep;
   logic [1:0]       num;
   logic             valid;
   logic             busy;
   logic             done;
   logic             full;
   logic [AW:0]      count;

   // Host side: drives commands, observes the stream and status.
   modport master (
      output wr_en, wr_data, clr, start, rep,
      input  num, valid, busy, done, full, count
   );

   // Generator side.
   modport slave (
      input  wr_en, wr_data, clr, start, rep,
      output num, valid, busy, done, full, count
   );
endinterface

// File: rtl/counting_gen.sv
// Symbol-stream generator: the host appends 2-bit symbols to a small buffer,
// then triggers playback, which emits the buffer one symbol per clock for a
// programmable number of back-to-back passes. Idle symbol is 2'b00.
module counting_gen #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int REP_W = 4
) (
   input logic           clk,
   input logic           reset,
   counting_gen_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [AW:0]      count_q, count_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [REP_W-1:0] reps_q, reps_d;
   logic [1:0]       num_q;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             mem_we;
   logic             full;
   logic [AW-1:0]    last_idx;

   // Symbol buffer; read through the registered num_q path.
   logic [1:0] mem [0:DEPTH-1];

   assign full     = (count_q == (AW+1)'(DEPTH));
   // Only meaningful while count_q > 0, which holds throughout SEND.
   assign last_idx = AW'(count_q - 1'b1);

   // Next-state logic: command decode in IDLE, pointer/pass tracking in SEND.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      reps_d   = reps_q;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      mem_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.clr) begin
               count_d = '0;
            end else if (bus.start) begin
               // Starting an empty buffer is a no-op; it still masks wr_en.
               if (count_q != '0) begin
                  reps_d   = (bus.rep == '0) ? REP_W'(1) : bus.rep;
                  rd_ptr_d = '0;
                  state_d  = SEND;
               end
            end else if (bus.wr_en && !full) begin
               mem_we  = 1'b1;
               count_d = count_q + 1'b1;
            end
         end
         SEND: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            if (rd_ptr_q == last_idx) begin
               if (reps_q > REP_W'(1)) begin
                  // Wrap straight into the next pass with no gap cycle.
                  rd_ptr_d = '0;
                  reps_d   = reps_q - 1'b1;
               end else begin
                  state_d = DONE;
               end
            end else begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and status registers; reset also empties the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rd_ptr_q <= '0;
         reps_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         reps_q   <= reps_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Buffer write port: appends at the current fill level.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[count_q[AW-1:0]] <= bus.wr_data;
      end
   end

   // Registered buffer read; outputs the idle symbol outside SEND.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_q <= 2'b00;
      end else if (state_q == SEND) begin
         num_q <= mem[rd_ptr_q];
      end else begin
         num_q <= 2'b00;
      end
   end

   assign bus.num   = num_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.full  = full;
   assign bus.count = count_q;

endmodule

// File: tb/tb_counting_gen.sv
// Directed testbench for counting_gen: hand-computed symbol streams checked
// cycle by cycle as {num, valid, busy, done}.
module tb_counting_gen;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int REP_W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   counting_gen_if #(.DEPTH(DEPTH), .AW(AW), .REP_W(REP_W)) bus_if ();

   counting_gen #(.DEPTH(DEPTH), .AW(AW), .REP_W(REP_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int vec_count = 0;
   int err_count = 0;

   // Captured {num, valid, busy, done} per cycle, index 0 = first valid slot.
   logic [4:0] cap [0:15];

   task automatic write_sym(input logic [1:0] s);
      @(negedge clk);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = s;
      @(negedge clk);
      bus_if.wr_en   = 1'b0;
   endtask

   task automatic clear_buf();
      @(negedge clk);
      bus_if.clr = 1'b1;
      @(negedge clk);
      bus_if.clr = 1'b0;
   endtask

   task automatic play(input logic [REP_W-1:0] r, input int n);
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.rep   = r;
      @(negedge clk);
      bus_if.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cap[i] = {bus_if.num, bus_if.valid, bus_if.busy, bus_if.done};
      end
      $display("playback rep=%0d: %0d cycles captured", r, n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      if ({bus_if.num, bus_if.valid, bus_if.busy, bus_if.done} !== 5'b00000) begin
         err_count++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {bus_if.num, bus_if.valid, bus_if.busy, bus_if.done}, 5'b00000);
      end
      vec_count++;
      if ({bus_if.count, bus_if.full} !== 5'b00000) begin
         err_count++;
         $display("FAIL reset_count: got count=%0d full=%0d expected 0/0",
                  bus_if.count, bus_if.full);
      end
      vec_count++;
      reset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [1:0] seq [0:2];
      logic [4:0] e;
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11;
      for (int i = 0; i < 3; i++) write_sym(seq[i]);
      if (bus_if.count !== 4'd3) begin
         err_count++;
         $display("FAIL basic_count: got %0d expected 3", bus_if.count);
      end
      vec_count++;
      play(4'd1, 6);
      for (int i = 0; i < 6; i++) begin
         e = (i < 3) ? {seq[i], 3'b110} : ((i == 3) ? 5'b00001 : 5'b00000);
         if (cap[i] !== e) begin
            err_count++;
            $display("FAIL basic_stream[%0d]: got %b expected %b", i, cap[i], e);
         end
         vec_count++;
      end
   endtask

   task automatic test_repeat();
      logic [1:0] seq [0:2];
      logic [4:0] e;
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11;
      play(4'd2, 9);
      for (int i = 0; i < 9; i++) begin
         e = (i < 6) ? {seq[i % 3], 3'b110} : ((i == 6) ? 5'b00001 : 5'b00000);
         if (cap[i] !== e) begin
            err_count++;
            $display("FAIL repeat_stream[%0d]: got %b expected %b", i, cap[i], e);
         end
         vec_count++;
      end
   endtask

   task automatic test_full();
      logic [1:0] s;
      logic [4:0] e;
      clear_buf();
      for (int i = 0; i < 9; i++) begin
         s = 2'((i % 3) + 1);
         write_sym(s);
         if (i >= 7) begin
            if ({bus_if.count, bus_if.full} !== {4'd8, 1'b1}) begin
               err_count++;
               $display("FAIL full_after_write%0d: got count=%0d full=%0d expected 8/1",
                        i + 1, bus_if.count, bus_if.full);
            end
            vec_count++;
         end
      end
      play(4'd1, 10);
      for (int i = 0; i < 10; i++) begin
         s = 2'((i % 3) + 1);
         e = (i < 8) ? {s, 3'b110} : ((i == 8) ? 5'b00001 : 5'b00000);
         if (cap[i] !== e) begin
            err_count++;
            $display("FAIL full_stream[%0d]: got %b expected %b", i, cap[i], e);
         end
         vec_count++;
      end
      clear_buf();
      if ({bus_if.count, bus_if.full} !== 5'b00000) begin
         err_count++;
         $display("FAIL full_clr: got count=%0d full=%0d expected 0/0",
                  bus_if.count, bus_if.full);
      end
      vec_count++;
   endtask

   task automatic test_empty_and_rep0();
      logic [4:0] e;
      play(4'd1, 4);
      for (int i = 0; i < 4; i++) begin
         if (cap[i] !== 5'b00000) begin
            err_count++;
            $display("FAIL empty_start[%0d]: got %b expected %b", i, cap[i], 5'b00000);
         end
         vec_count++;
      end
      write_sym(2'b10);
      write_sym(2'b01);
      play(4'd0, 4);
      for (int i = 0; i < 4; i++) begin
         e = (i == 0) ? 5'b10110 : (i == 1) ? 5'b01110 : (i == 2) ? 5'b00001 : 5'b00000;
         if (cap[i] !== e) begin
            err_count++;
            $display("FAIL rep0_stream[%0d]: got %b expected %b", i, cap[i], e);
         end
         vec_count++;
      end
   endtask

   task automatic test_ignore_during_send();
      logic [1:0] seq [0:2];
      logic [4:0] e;
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11;
      clear_buf();
      for (int i = 0; i < 3; i++) write_sym(seq[i]);
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.rep   = 4'd2;
      @(negedge clk);
      // Hammer every command while playback is running.
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = 2'b11;
      bus_if.clr     = 1'b1;
      bus_if.rep     = 4'd5;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         cap[i] = {bus_if.num, bus_if.valid, bus_if.busy, bus_if.done};
         if (i == 4) begin
            bus_if.wr_en = 1'b0;
            bus_if.clr   = 1'b0;
            bus_if.start = 1'b0;
         end
      end
      $display("playback rep=2 with commands during SEND: 9 cycles captured");
      for (int i = 0; i < 9; i++) begin
         e = (i < 6) ? {seq[i % 3], 3'b110} : ((i == 6) ? 5'b00001 : 5'b00000);
         if (cap[i] !== e) begin
            err_count++;
            $display("FAIL send_ignore[%0d]: got %b expected %b", i, cap[i], e);
         end
         vec_count++;
      end
      if (bus_if.count !== 4'd3) begin
         err_count++;
         $display("FAIL send_ignore_count: got %0d expected 3", bus_if.count);
      end
      vec_count++;
   endtask

   task automatic test_clr_start();
      logic [4:0] o;
      @(negedge clk);
      bus_if.clr   = 1'b1;
      bus_if.start = 1'b1;
      bus_if.rep   = 4'd1;
      @(negedge clk);
      bus_if.clr   = 1'b0;
      bus_if.start = 1'b0;
      if (bus_if.count !== 4'd0) begin
         err_count++;
         $display("FAIL clr_start_count: got %0d expected 0", bus_if.count);
      end
      vec_count++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         o = {bus_if.num, bus_if.valid, bus_if.busy, bus_if.done};
         if (o !== 5'b00000) begin
            err_count++;
            $display("FAIL clr_start_idle[%0d]: got %b expected %b", i, o, 5'b00000);
         end
         vec_count++;
      end
      $display("clr+start in IDLE: 4 idle cycles observed");
   endtask

   task automatic test_reset_mid();
      logic [4:0] o;
      write_sym(2'b01);
      write_sym(2'b10);
      write_sym(2'b11);
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.rep   = 4'd1;
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      o = {bus_if.num, bus_if.valid, bus_if.busy, bus_if.done};
      if (o !== 5'b10110) begin
         err_count++;
         $display("FAIL reset_mid_2nd: got %b expected %b", o, 5'b10110);
      end
      vec_count++;
      reset = 1'b1;
      @(negedge clk);
      o = {bus_if.num, bus_if.valid, bus_if.busy, bus_if.done};
      if ({o, bus_if.count} !== 9'd0) begin
         err_count++;
         $display("FAIL reset_mid_abort: got out=%b count=%0d expected 00000/0",
                  o, bus_if.count);
      end
      vec_count++;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         o = {bus_if.num, bus_if.valid, bus_if.busy, bus_if.done};
         if (o !== 5'b00000) begin
            err_count++;
            $display("FAIL reset_mid_after[%0d]: got %b expected %b", i, o, 5'b00000);
         end
         vec_count++;
      end
      $display("reset during playback: aborted");
   endtask

   initial begin
      reset          = 1'b1;
      bus_if.wr_en   = 1'b0;
      bus_if.wr_data = 2'b00;
      bus_if.clr     = 1'b0;
      bus_if.start   = 1'b0;
      bus_if.rep     = '0;
      test_reset();
      test_basic();
      test_repeat();
      test_full();
      test_empty_and_rep0();
      test_ignore_during_send();
      test_clr_start();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end
endmodule

// File: doc/counting_gen.md
Name: counting_gen

Overview:
- Transmitter side of the 2-bit symbol stream (`num`) consumed by the team's sequence-detector blocks.
- The host loads a short programmed symbol sequence into an internal buffer, then triggers playback.
- Playback emits one symbol per clock, repeated a programmable number of times.
- Outside playback the block drives the idle symbol 2'b00, which never advances a detector.

Parameters:
DEPTH, 8, number of symbol slots in the buffer (power of two, >= 2)
AW, 3, address width, log2(DEPTH)
REP_W, 4, width of the repeat-count input

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  append wr_data to buffer (honoured in IDLE only)
wr_data  input  2  symbol to append
clr  input  1  empty the buffer (honoured in IDLE only)
start  input  1  begin playback (honoured in IDLE only)
rep  input  REP_W  number of passes over the buffer, sampled with start; 0 treated as 1
num  output  2  emitted symbol, registered; 2'b00 when valid=0
valid  output  1  num carries a programmed symbol this cycle
busy  output  1  playback in progress (SEND state)
done  output  1  one-cycle pulse after the final symbol
full  output  1  count == DEPTH
count  output  AW+1  number of loaded symbols, 0..DEPTH

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=IDLE; num=2'b00; valid=0; busy=0; done=0.
  - count=0, full=0, read pointer 0, repeat counter 0.
  - Buffer contents don't care.
- Reset mid-playback aborts immediately. No done pulse is produced. The buffer is emptied.
- States:
  - IDLE:
    - Priority each cycle: clr > start > wr_en.
    - clr: count<=0.
    - start with count>0: latch reps=(rep==0)?1:rep, rd_ptr<=0, go to SEND.
    - start with count==0: ignored; stay IDLE, no done.
    - wr_en with count<DEPTH: buf[count]<=wr_data, count<=count+1.
    - wr_en with full=1: write dropped, count unchanged.
  - SEND:
    - Each cycle: num<=buf[rd_ptr], valid<=1, busy<=1.
    - If rd_ptr==count-1 and reps>1: rd_ptr<=0, reps<=reps-1 (wrap to the next pass, no gap cycle).
    - If rd_ptr==count-1 and reps==1: go to DONE.
    - Otherwise rd_ptr<=rd_ptr+1.
    - wr_en, clr and start are ignored throughout SEND.
  - DONE: valid<=0, num<=2'b00, busy<=0, done<=1 for exactly one cycle, then IDLE. Inputs are ignored in DONE.
- Timing (start sampled high at edge T in IDLE):
  - First symbol is visible after edge T+1.
  - valid is high for exactly count*reps consecutive cycles.
  - done is high in the cycle immediately following the last valid cycle.
  - busy equals valid during playback.
  - The next start is accepted no earlier than the cycle after done.
- Buffer contents and count persist across playbacks. Only clr or reset empties them.
- full is combinational from count. count and full are stable during SEND.
- No arithmetic overflow: count saturates at DEPTH. reps is REP_W bits, maximum 2^REP_W-1.

Test Plan:
- Load 01,10,11 (count=3), start rep=1 → num=01,10,11 on 3 consecutive valid cycles, then done=1 for one cycle, num=00. A detector fed this stream asserts its match output.
- Same buffer, start rep=2 → 6 valid cycles 01,10,11,01,10,11 with no gap, single done pulse, busy high for exactly 6 cycles.
- Write 9 symbols with DEPTH=8 → count=8, full=1 after the 8th, 9th dropped. Playback emits only the first 8. clr then gives count=0, full=0.
- start with count=0 → no valid, busy, or done; state remains IDLE. rep=0 with count=2 → exactly 2 valid cycles (treated as 1).
- Assert wr_en, clr and start during SEND → stream unchanged, count unchanged. Same-cycle clr+start in IDLE → buffer cleared, no playback.
- Assert reset on the 2nd valid cycle of a 3-symbol playback → next cycle num=00, valid=0, busy=0, done=0, count=0.
